fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the 5-stage pipeline: owns the program counter, issues read requests to instruction memory, and loads the IF/ID register whose outputs (`DR`, `npc`) feed `decode_stage`. It produces the instruction word that decode consumes. It honours a hazard-unit stall and a branch/jump redirect with flush, and it tolerates instruction-memory wait states through a request/ready handshake.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- `clk`  in  1: pipeline clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hazard unit; hold PC and IF/ID.
- `pc_src`  in  1: redirect (taken branch/jump) this cycle.
- `branch_target`  in  32: redirect address; bits [1:0] forced to 0 internally.
- `imem_req`  out  1: read request to instruction memory.
- `imem_addr`  out  32: read address. Stable while `imem_req` is high and `imem_ready` is low.
- `imem_ready`  in  1: `imem_rdata` is valid this cycle for `imem_addr`.
- `imem_rdata`  in  32: instruction word.
- `DR`  out  32: IF/ID instruction register.
- `npc`  out  32: IF/ID PC+4 of the instruction in `DR`.
- `dr_valid`  out  1: `DR` holds a real instruction (0 = bubble/NOP).

## Operation
- FSM states: FETCH (normal) and DRAIN (discard an in-flight read after a redirect). Reset state is FETCH.
- `imem_req` = !rst in both states. `imem_addr` = `pc`.
- A read is accepted when `accept = imem_req & imem_ready & !stall & !pc_src & state==FETCH`.
  - On accept: `DR` <= `imem_rdata`, `npc` <= pc+4, `dr_valid` <= 1, `pc` <= pc+4.
  - PC arithmetic is modulo 2^32: 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect (`pc_src`=1) in FETCH:
  - Always: `DR` <= NOP (32'h0000_0000), `dr_valid` <= 0.
  - If `imem_ready`=1, or `imem_req`=0: `pc` <= {branch_target[31:2],2'b00} and stay in FETCH. Returning data is dropped.
  - If `imem_req`=1 and `imem_ready`=0: `tgt_q` <= aligned target, go to DRAIN, `pc` unchanged. This keeps the address stable for the pending read.
- In DRAIN: `imem_req`=1 at the old `pc`. Data is never captured. `DR`/`dr_valid` hold NOP/0.
  - On `imem_ready`: `pc` <= `tgt_q`, go to FETCH.
  - A new `pc_src` during DRAIN overwrites `tgt_q`; the latest redirect wins.
- Stall (`stall`=1, `pc_src`=0): `pc`, `DR`, `npc`, `dr_valid` all hold. `imem_req` stays high at the same address. Memory may keep `imem_ready` high and re-present the data.
- Priority: `rst` > `pc_src` > `stall` > accept.
- No accept and no redirect (memory wait, FETCH): `pc` holds; IF/ID holds its previous contents.

## Timing
- Reset values: `pc`=RESET_PC, `imem_addr`=RESET_PC, `imem_req`=0, `DR`=0, `npc`=0, `dr_valid`=0, `tgt_q`=0, state=FETCH.
- First request is in the first cycle after `rst` deasserts.
- With zero-wait memory (`imem_ready` tied 1): throughput is 1 instruction/cycle. `DR` updates on the edge that ends the accept cycle, so latency is 1 cycle from address to `DR`.
- Redirect penalty with zero-wait memory: 1 bubble. The target address is on `imem_addr` the cycle after `pc_src`.
- Redirect during a wait state costs the remaining wait cycles of the old read plus 1.
- `rst` asserted mid-DRAIN or mid-wait aborts immediately. The pending read is abandoned; memory must accept an address change on `rst`.

## Structure
- `pipeline_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0000
  - fetch FSM state enum (`FETCH`, `DRAIN`)
  - `INSTR_W` = 32
- Natural sub-module: `pc_register`. It contains the next-PC mux (pc+4 / aligned target / `tgt_q` / hold) and the PC flop with reset to RESET_PC. The FSM and IF/ID register stay in `fetch_stage`.

## Test plan
- Reset then `imem_ready`=1, memory returns addr^0xA5A5_0000:
  - `imem_addr` sequence is 0x0, 0x4, 0x8.
  - `DR`=0xA5A5_0000, 0xA5A5_0004, … on consecutive cycles.
  - `npc`=0x4, 0x8, …; `dr_valid`=1 from the 2nd cycle on.
- `stall`=1 for 3 cycles at pc=0x10: `imem_addr` holds 0x10, and `DR`/`npc` hold for 3 cycles. The cycle after release, `DR`=mem[0x10] and `npc`=0x14.
- `pc_src`=1, `branch_target`=0x0000_0103 with zero-wait memory:
  - next cycle `imem_addr`=0x100, `DR`=0, `dr_valid`=0;
  - following cycle `DR`=mem[0x100].
- `imem_ready` low for 4 cycles at pc=0x20, `pc_src` (target 0x200) in cycle 2:
  - `imem_addr` stays 0x20 until ready;
  - the returning data is not captured;
  - next `imem_addr`=0x200;
  - a second redirect to 0x300 during DRAIN makes the next address 0x300.
- `RESET_PC`=0xFFFF_FFF8: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. `npc` for the 0xFFFF_FFFC instruction is 0x0.
- `pc_src`, `stall` and `imem_ready` all high in one cycle: the redirect wins and `DR` becomes NOP. Then `rst` asserted mid-DRAIN gives all reset values on the next edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stages.
// Holds the fetch FSM state encoding and the next-PC select codes.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_TGTQ   = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel: request/address out, ready/data back.
interface fetch_stage_if;
  import pipeline_pkg::*;

  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_register.sv
// Program counter flop with its next-PC mux.
// Increment wraps modulo 2^32; targets arrive already word-aligned.
module pc_register
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_e     sel,
  input  logic [31:0] target,
  input  logic [31:0] tgt_q,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      PC_HOLD:   pc_d = pc_q;
      PC_INC:    pc_d = pc_plus4;
      PC_TARGET: pc_d = target;
      PC_TGTQ:   pc_d = tgt_q;
      default:   pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues imem reads at the PC and loads the IF/ID register.
// A redirect that lands while a read is outstanding parks in DRAIN until that read returns.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [31:0]        branch_target,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] DR,
  output logic [31:0]        npc,
  output logic               dr_valid
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [INSTR_W-1:0] dr_q, dr_d;
  logic [31:0]        npc_q, npc_d;
  logic               valid_q, valid_d;

  pc_sel_e     pc_sel;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] aligned_target;
  logic        imem_req;
  logic        accept;

  assign aligned_target = branch_target & ~32'h0000_0003;
  assign imem_req       = !rst;
  assign accept         = imem_req & imem.imem_ready & !stall & !pc_src & (state_q == FETCH);

  assign imem.imem_req  = imem_req;
  assign imem.imem_addr = pc;
  assign DR             = dr_q;
  assign npc            = npc_q;
  assign dr_valid       = valid_q;

  pc_register #(.RESET_PC(RESET_PC)) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .sel      (pc_sel),
    .target   (aligned_target),
    .tgt_q    (tgt_q),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dr_d    = dr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    pc_sel  = PC_HOLD;
    unique case (state_q)
      FETCH: begin
        if (pc_src) begin
          dr_d    = NOP_INSTR;
          valid_d = 1'b0;
          if (imem.imem_ready || !imem_req) begin
            pc_sel = PC_TARGET;
          end else begin
            tgt_d   = aligned_target;
            state_d = DRAIN;
          end
        end else if (accept) begin
          dr_d    = imem.imem_rdata;
          npc_d   = pc_plus4;
          valid_d = 1'b1;
          pc_sel  = PC_INC;
        end
      end
      DRAIN: begin
        // The outstanding read is discarded; a same-cycle redirect beats the parked target.
        dr_d    = NOP_INSTR;
        valid_d = 1'b0;
        if (pc_src) begin
          tgt_d = aligned_target;
        end
        if (imem.imem_ready) begin
          pc_sel  = pc_src ? PC_TARGET : PC_TGTQ;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      tgt_q   <= 32'h0000_0000;
      dr_q    <= NOP_INSTR;
      npc_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      dr_q    <= dr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 32'hA5A5_0000.
// A second instance with RESET_PC = 0xFFFF_FFF8 covers PC wrap-around.
module tb_fetch_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        ready = 1'b1;
  logic [31:0] dr;
  logic [31:0] npc;
  logic        dr_valid;

  logic        rst2 = 1'b1;
  logic [31:0] dr2;
  logic [31:0] npc2;
  logic        dr_valid2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  assign bus.imem_ready  = ready;
  assign bus.imem_rdata  = bus.imem_addr ^ 32'hA5A5_0000;
  assign bus2.imem_ready = 1'b1;
  assign bus2.imem_rdata = bus2.imem_addr ^ 32'hA5A5_0000;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .imem(bus.master),
    .DR(dr), .npc(npc), .dr_valid(dr_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .pc_src(1'b0),
    .branch_target(32'h0), .imem(bus2.master),
    .DR(dr2), .npc(npc2), .dr_valid(dr_valid2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 00000000", bus.imem_addr); end
    checks++; if (dr !== 32'h0) begin errors++; $display("[TB] FAIL rst_dr: got %h expected 00000000", dr); end
    checks++; if (npc !== 32'h0) begin errors++; $display("[TB] FAIL rst_npc: got %h expected 00000000", npc); end
    checks++; if (dr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", dr_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", bus.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'(i) * 32'd4;
      checks++; if (bus.imem_addr !== exp_addr) begin errors++; $display("[TB] FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr, exp_addr); end
      step();
      checks++; if (dr !== (exp_addr ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL seq_dr%0d: got %h expected %h", i, dr, exp_addr ^ 32'hA5A5_0000); end
      checks++; if (npc !== exp_addr + 32'd4) begin errors++; $display("[TB] FAIL seq_npc%0d: got %h expected %h", i, npc, exp_addr + 32'd4); end
      checks++; if (dr_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid%0d: got %b expected 1", i, dr_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_addr%0d: got %h expected 00000010", i, bus.imem_addr); end
      checks++; if (dr !== 32'hA5A5_000C) begin errors++; $display("[TB] FAIL stall_dr%0d: got %h expected a5a5000c", i, dr); end
      checks++; if (npc !== 32'h10) begin errors++; $display("[TB] FAIL stall_npc%0d: got %h expected 00000010", i, npc); end
    end
    stall = 1'b0;
    step();
    checks++; if (dr !== 32'hA5A5_0010) begin errors++; $display("[TB] FAIL unstall_dr: got %h expected a5a50010", dr); end
    checks++; if (npc !== 32'h14) begin errors++; $display("[TB] FAIL unstall_npc: got %h expected 00000014", npc); end
  endtask

  task automatic test_redirect();
    pc_src = 1'b1;
    branch_target = 32'h0000_0103;
    step();
    pc_src = 1'b0;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 00000100", bus.imem_addr); end
    checks++; if (dr !== 32'h0) begin errors++; $display("[TB] FAIL redir_dr: got %h expected 00000000", dr); end
    checks++; if (dr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %b expected 0", dr_valid); end
    step();
    checks++; if (dr !== 32'hA5A5_0100) begin errors++; $display("[TB] FAIL redir_dr2: got %h expected a5a50100", dr); end
    checks++; if (npc !== 32'h104) begin errors++; $display("[TB] FAIL redir_npc2: got %h expected 00000104", npc); end
  endtask

  task automatic test_wait_drain();
    pc_src = 1'b1;
    branch_target = 32'h20;
    step();
    pc_src = 1'b0;
    ready = 1'b0;
    step();
    checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL wait_addr1: got %h expected 00000020", bus.imem_addr); end
    pc_src = 1'b1;
    branch_target = 32'h200;
    step();
    pc_src = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL drain_addr%0d: got %h expected 00000020", i, bus.imem_addr); end
      step();
    end
    ready = 1'b1;
    step();
    checks++; if (dr !== 32'h0) begin errors++; $display("[TB] FAIL drain_dr: got %h expected 00000000", dr); end
    checks++; if (dr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b expected 0", dr_valid); end
    checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL drain_next: got %h expected 00000200", bus.imem_addr); end
    step();
    checks++; if (dr !== 32'hA5A5_0200) begin errors++; $display("[TB] FAIL drain_dr2: got %h expected a5a50200", dr); end
    ready = 1'b0;
    pc_src = 1'b1;
    branch_target = 32'h40;
    step();
    branch_target = 32'h300;
    step();
    pc_src = 1'b0;
    checks++; if (bus.imem_addr !== 32'h204) begin errors++; $display("[TB] FAIL drain2_addr: got %h expected 00000204", bus.imem_addr); end
    ready = 1'b1;
    step();
    checks++; if (bus.imem_addr !== 32'h300) begin errors++; $display("[TB] FAIL drain2_next: got %h expected 00000300", bus.imem_addr); end
    step();
    checks++; if (dr !== 32'hA5A5_0300) begin errors++; $display("[TB] FAIL drain2_dr: got %h expected a5a50300", dr); end
    checks++; if (npc !== 32'h304) begin errors++; $display("[TB] FAIL drain2_npc: got %h expected 00000304", npc); end
  endtask

  task automatic test_wrap();
    rst2 = 1'b0;
    #1;
    checks++; if (bus2.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected fffffff8", bus2.imem_addr); end
    step();
    checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected fffffffc", bus2.imem_addr); end
    checks++; if (dr2 !== 32'h5A5A_FFF8) begin errors++; $display("[TB] FAIL wrap_dr1: got %h expected 5a5afff8", dr2); end
    step();
    checks++; if (bus2.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr2: got %h expected 00000000", bus2.imem_addr); end
    checks++; if (dr2 !== 32'h5A5A_FFFC) begin errors++; $display("[TB] FAIL wrap_dr2: got %h expected 5a5afffc", dr2); end
    checks++; if (npc2 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_npc2: got %h expected 00000000", npc2); end
  endtask

  task automatic test_priority();
    pc_src = 1'b1;
    stall = 1'b1;
    ready = 1'b1;
    branch_target = 32'h400;
    step();
    checks++; if (dr !== 32'h0) begin errors++; $display("[TB] FAIL prio_dr: got %h expected 00000000", dr); end
    checks++; if (dr_valid !== 1'b0) begin errors++; $display("[TB] FAIL prio_valid: got %b expected 0", dr_valid); end
    checks++; if (bus.imem_addr !== 32'h400) begin errors++; $display("[TB] FAIL prio_addr: got %h expected 00000400", bus.imem_addr); end
    stall = 1'b0;
    ready = 1'b0;
    branch_target = 32'h500;
    step();
    pc_src = 1'b0;
    checks++; if (bus.imem_addr !== 32'h400) begin errors++; $display("[TB] FAIL prio_drain_addr: got %h expected 00000400", bus.imem_addr); end
    rst = 1'b1;
    step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_req: got %b expected 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL abort_addr: got %h expected 00000000", bus.imem_addr); end
    checks++; if (dr !== 32'h0 || npc !== 32'h0 || dr_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_ifid: got dr=%h npc=%h v=%b expected 0/0/0", dr, npc, dr_valid); end
    rst = 1'b0;
    ready = 1'b1;
    step();
    checks++; if (dr !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL abort_refetch_dr: got %h expected a5a50000", dr); end
    checks++; if (bus.imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL abort_refetch_addr: got %h expected 00000004", bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wait_drain();
    test_wrap();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
